// File: rtl/spi_mem_pkg.sv
// Shared types and helpers for the SPI burst memory slave: FSM states, command
// encodings and the burst address-advance rule.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    RTURN,
    RDATA
  } state_t;

  localparam logic CMD_WR = 1'b0;
  localparam logic CMD_RD = 1'b1;

  // Burst address advance: the last word either wraps to 0 or is revisited.
  function automatic int unsigned next_addr(input int unsigned addr,
                                            input int unsigned depth,
                                            input bit          wrap_en);
    if (addr == depth - 1) return wrap_en ? 0 : depth - 1;
    return addr + 1;
  endfunction

endpackage

// File: rtl/spi_mem_array.sv
// Word memory with one synchronous write port and one registered read port.
// Addresses at or beyond MEM_DEPTH drop writes and read back as zero.
module spi_mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_wr_ok;
  logic                  w_rd_ok;

  assign w_wr_ok = 32'(i_waddr) < MEM_DEPTH;
  assign w_rd_ok = 32'(i_raddr) < MEM_DEPTH;

  // NOTE: the array has no reset so it maps onto plain RAM and keeps its
  // contents across a mid-frame reset.
  always_ff @(posedge clk) begin
    if (i_we && w_wr_ok) r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= w_rd_ok ? r_mem[i_raddr[IDX_W-1:0]] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_burst_mem_slave.sv
// SPI slave fused with an on-chip memory: cmd bit, MSB-first address, then a
// burst of auto-incrementing data words while SS_n stays low.
module spi_burst_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter bit WRAP_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_abort
);

  localparam int SHW   = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (SHW > 1) ? $clog2(SHW) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cmd;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [SHW-2:0]        r_rx_shift;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-2:0] r_tx_shift;
  logic                  r_miso;
  logic                  r_abort;

  logic                  w_abort;
  logic                  w_we;
  logic                  w_re;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ADDR_WIDTH-1:0] w_addr_full;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_addr_full = {r_rx_shift[ADDR_WIDTH-2:0], MOSI};
  assign w_wdata     = {r_rx_shift[DATA_WIDTH-2:0], MOSI};
  assign w_next_addr = ADDR_WIDTH'(next_addr(32'(r_addr), MEM_DEPTH, WRAP_EN));

  spi_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_we),
    .i_waddr(r_addr),
    .i_wdata(w_wdata),
    .i_re   (w_re),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  // NOTE: every comb output gets a default before the case so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_we        = 1'b0;
    w_re        = 1'b0;
    w_raddr     = w_next_addr;
    case (r_state)
      IDLE: if (!SS_n) w_state_nxt = ADDR;
      ADDR: begin
        if (SS_n) begin
          w_state_nxt = IDLE;
          w_abort     = 1'b1;
        end else if (r_bit_cnt == ADDR_LAST) begin
          w_state_nxt = (r_cmd == CMD_RD) ? RTURN : WDATA;
          // The first read word lands in the read register during RTURN.
          w_re        = (r_cmd == CMD_RD);
          w_raddr     = w_addr_full;
        end
      end
      WDATA: begin
        if (SS_n) begin
          w_state_nxt = IDLE;
          w_abort     = (r_bit_cnt != '0);
        end else if (r_bit_cnt == DATA_LAST) begin
          w_we = 1'b1;
        end
      end
      RTURN: begin
        w_state_nxt = SS_n ? IDLE : RDATA;
        w_abort     = SS_n;
      end
      RDATA: begin
        if (SS_n) begin
          w_state_nxt = IDLE;
          w_abort     = (r_bit_cnt != '0);
        end else if (r_bit_cnt == '0) begin
          w_re = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cmd      <= CMD_WR;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_addr     <= '0;
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= w_abort;
      r_miso  <= 1'b0;
      case (r_state)
        IDLE: if (!SS_n) begin
          r_cmd     <= MOSI;
          r_bit_cnt <= '0;
        end
        ADDR: if (!SS_n) begin
          r_rx_shift <= {r_rx_shift[SHW-3:0], MOSI};
          if (r_bit_cnt == ADDR_LAST) begin
            r_addr    <= w_addr_full;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        WDATA: if (!SS_n) begin
          r_rx_shift <= {r_rx_shift[SHW-3:0], MOSI};
          if (r_bit_cnt == DATA_LAST) begin
            r_addr    <= w_next_addr;
            r_bit_cnt <= '0;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        RTURN: if (!SS_n) begin
          r_tx_shift <= w_rdata[DATA_WIDTH-2:0];
          r_miso     <= w_rdata[DATA_WIDTH-1];
          r_bit_cnt  <= '0;
        end
        RDATA: if (!SS_n) begin
          if (r_bit_cnt == DATA_LAST) begin
            r_tx_shift <= w_rdata[DATA_WIDTH-2:0];
            r_miso     <= w_rdata[DATA_WIDTH-1];
            r_addr     <= w_next_addr;
            r_bit_cnt  <= '0;
          end else begin
            r_tx_shift <= {r_tx_shift[DATA_WIDTH-3:0], 1'b0};
            r_miso     <= r_tx_shift[DATA_WIDTH-2];
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign MISO        = r_miso;
  assign busy        = (r_state != IDLE);
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_burst_mem_slave.sv
// Directed bench: three slaves (default, no-wrap, 200-word) share SS_n/MOSI;
// each scenario task checks the instance whose configuration it targets.
module tb_spi_burst_mem_slave;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic miso_def, busy_def, fa_def;
  logic miso_nw,  busy_nw,  fa_nw;
  logic miso_d2,  busy_d2,  fa_d2;

  int n_cmp = 0;
  int n_err = 0;
  int ab_def = 0;
  int ab_d2  = 0;

  always #5 clk = ~clk;

  spi_burst_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .WRAP_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_def), .busy(busy_def), .frame_abort(fa_def));

  spi_burst_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(256), .WRAP_EN(1'b0)) u_dut_nw (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_nw), .busy(busy_nw), .frame_abort(fa_nw));

  spi_burst_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(200), .WRAP_EN(1'b1)) u_dut_d2 (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(miso_d2), .busy(busy_d2), .frame_abort(fa_d2));

  always @(negedge clk) begin
    if (fa_def === 1'b1) ab_def++;
    if (fa_d2 === 1'b1)  ab_d2++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input logic cmd);
    @(negedge clk);
    SS_n = 1'b0;
    MOSI = cmd;
  endtask

  task automatic send_bits(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      MOSI = v[i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic write_frame(input logic [7:0] addr, input logic [23:0] data, input int nw);
    start_frame(1'b0);
    send_bits(addr);
    for (int w = nw - 1; w >= 0; w--) send_bits(data[w*8 +: 8]);
    end_frame();
  endtask

  // Captures nw words from every instance, MSB first, into the low bits.
  task automatic read_frame(input logic [7:0] addr, input int nw,
                            output logic [31:0] q_def, output logic [31:0] q_nw,
                            output logic [31:0] q_d2, output int busy_low);
    q_def = '0; q_nw = '0; q_d2 = '0; busy_low = 0;
    start_frame(1'b1);
    send_bits(addr);
    @(negedge clk);
    MOSI = 1'b0;
    for (int b = 0; b < nw * 8; b++) begin
      @(negedge clk);
      q_def = {q_def[30:0], miso_def};
      q_nw  = {q_nw[30:0],  miso_nw};
      q_d2  = {q_d2[30:0],  miso_d2};
      if (busy_def !== 1'b1) busy_low++;
    end
    end_frame();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    #1;
    n_cmp++; if (miso_def !== 1'b0) begin n_err++; $display("FAIL reset_miso got=%b exp=0", miso_def); end
    n_cmp++; if (busy_def !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_def); end
    n_cmp++; if (fa_def !== 1'b0)   begin n_err++; $display("FAIL reset_abort got=%b exp=0", fa_def); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] qd, qn, q2;
    int bl, ab0;
    ab0 = ab_def;
    write_frame(8'h12, 24'h0000A5, 1);
    read_frame(8'h12, 1, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0000_00A5) begin n_err++; $display("FAIL single_rd got=%h exp=000000a5", qd); end
    n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL single_busy low_bits=%0d exp=0", bl); end
    n_cmp++; if (ab_def !== ab0) begin n_err++; $display("FAIL single_abort pulses=%0d exp=0", ab_def - ab0); end
    n_cmp++; if (busy_def !== 1'b0) begin n_err++; $display("FAIL single_idle_busy got=%b exp=0", busy_def); end
  endtask

  task automatic test_burst();
    logic [31:0] qd, qn, q2;
    int bl;
    write_frame(8'h40, 24'h010203, 3);
    read_frame(8'h40, 3, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0001_0203) begin n_err++; $display("FAIL burst_def got=%h exp=00010203", qd); end
    n_cmp++; if (q2 !== 32'h0001_0203) begin n_err++; $display("FAIL burst_d200 got=%h exp=00010203", q2); end
    n_cmp++; if (bl !== 0) begin n_err++; $display("FAIL burst_busy low_bits=%0d exp=0", bl); end
  endtask

  task automatic test_wrap();
    logic [31:0] qd, qn, q2;
    int bl;
    write_frame(8'h00, 24'h00005A, 1);
    write_frame(8'hFF, 24'h00EE11, 2);
    read_frame(8'h00, 1, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0000_0011) begin n_err++; $display("FAIL wrap_addr0 got=%h exp=00000011", qd); end
    n_cmp++; if (qn !== 32'h0000_005A) begin n_err++; $display("FAIL nowrap_addr0 got=%h exp=0000005a", qn); end
    read_frame(8'hFF, 2, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0000_EE11) begin n_err++; $display("FAIL wrap_burst_rd got=%h exp=0000ee11", qd); end
    n_cmp++; if (qn !== 32'h0000_1111) begin n_err++; $display("FAIL nowrap_burst_rd got=%h exp=00001111", qn); end
  endtask

  task automatic test_abort();
    logic [31:0] qd, qn, q2;
    int bl, ab0;
    write_frame(8'h30, 24'h0000C3, 1);
    ab0 = ab_def;
    start_frame(1'b0);
    send_bits(8'h30);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MOSI = i[0];
    end
    @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (fa_def !== 1'b1)   begin n_err++; $display("FAIL abort_wdata_pulse got=%b exp=1", fa_def); end
    n_cmp++; if (busy_def !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy_def); end
    @(negedge clk);
    n_cmp++; if (fa_def !== 1'b0)   begin n_err++; $display("FAIL abort_pulse_width got=%b exp=0", fa_def); end
    n_cmp++; if (ab_def - ab0 !== 1) begin n_err++; $display("FAIL abort_count got=%0d exp=1", ab_def - ab0); end
    start_frame(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      MOSI = 1'b1;
    end
    @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (fa_def !== 1'b1) begin n_err++; $display("FAIL abort_addr_pulse got=%b exp=1", fa_def); end
    @(negedge clk);
    read_frame(8'h30, 1, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0000_00C3) begin n_err++; $display("FAIL abort_mem_kept got=%h exp=000000c3", qd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] qd, qn, q2;
    int bl;
    write_frame(8'hC8, 24'h000077, 1);
    read_frame(8'hC8, 1, qd, qn, q2, bl);
    n_cmp++; if (q2 !== 32'h0000_0000) begin n_err++; $display("FAIL oor_rd got=%h exp=00000000", q2); end
    n_cmp++; if (qd !== 32'h0000_0077) begin n_err++; $display("FAIL inrange_rd got=%h exp=00000077", qd); end
    write_frame(8'hC7, 24'h000033, 1);
    write_frame(8'hC8, 24'h000044, 1);
    read_frame(8'hC7, 1, qd, qn, q2, bl);
    n_cmp++; if (q2 !== 32'h0000_0033) begin n_err++; $display("FAIL last_word_rd got=%h exp=00000033", q2); end
    read_frame(8'hC8, 1, qd, qn, q2, bl);
    n_cmp++; if (q2 !== 32'h0000_0000) begin n_err++; $display("FAIL oor_rd2 got=%h exp=00000000", q2); end
  endtask

  task automatic test_async_reset();
    logic [31:0] qd, qn, q2;
    int bl;
    write_frame(8'h55, 24'h000096, 1);
    start_frame(1'b1);
    send_bits(8'h55);
    @(negedge clk);
    MOSI = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (miso_def !== 1'b1) begin n_err++; $display("FAIL rst_pre_miso got=%b exp=1", miso_def); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (miso_def !== 1'b0) begin n_err++; $display("FAIL rst_mid_miso got=%b exp=0", miso_def); end
    n_cmp++; if (busy_def !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got=%b exp=0", busy_def); end
    @(negedge clk);
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_frame(8'h55, 1, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0000_0096) begin n_err++; $display("FAIL rst_keep_55 got=%h exp=00000096", qd); end
    read_frame(8'h12, 1, qd, qn, q2, bl);
    n_cmp++; if (qd !== 32'h0000_00A5) begin n_err++; $display("FAIL rst_keep_12 got=%h exp=000000a5", qd); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_abort();
    test_out_of_range();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
